// File: rtl/pio_pkg.sv
// Shared definitions for the edge-capturing parallel input port.
// This file holds the register word addresses and the bus widths.
package pio_pkg;

   localparam int unsigned BUS_W  = 32;
   localparam int unsigned ADDR_W = 3;

   localparam logic [ADDR_W-1:0] ADDR_DATA = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_RISE = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_MASK = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_CAP  = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_FALL = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_DB   = 3'd5;

endpackage

// File: rtl/pio_edge_in_if.sv
// Register-slave bus of pio_edge_in: word-addressed writes, registered reads, level irq.
interface pio_edge_in_if;
   import pio_pkg::*;

   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [BUS_W-1:0]  writedata;
   logic [BUS_W-1:0]  readdata;
   logic              irq;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq
   );

endinterface

// File: rtl/pio_debounce_bit.sv
// One input bit: two-flop synchroniser, threshold debounce filter, and one-cycle delayed copy.
module pio_debounce_bit #(
   parameter int unsigned DB_BITS = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_bit,
   input  logic [DB_BITS-1:0] db_thresh,
   output logic               filt,
   output logic               filt_d
);

   logic               d1;
   logic               d2;
   logic [DB_BITS-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d1     <= 1'b0;
         d2     <= 1'b0;
         filt   <= 1'b0;
         filt_d <= 1'b0;
         cnt    <= '0;
      end else begin
         d1     <= in_bit;
         d2     <= d1;
         filt_d <= filt;
         if (d2 == filt) begin
            cnt <= '0;
         // >= so a threshold lowered below the running count fires at once
         end else if (cnt >= db_thresh) begin
            filt <= d2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + DB_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/pio_edge_in.sv
// Debounced parallel input port with per-bit rise/fall edge capture and masked level interrupt.
module pio_edge_in
   import pio_pkg::*;
#(
   parameter int unsigned      WIDTH         = 8,
   parameter int unsigned      DB_BITS       = 16,
   parameter logic [WIDTH-1:0] RESET_RISE_EN = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_port,
   pio_edge_in_if.slave     bus
);

   logic [WIDTH-1:0]   filt;
   logic [WIDTH-1:0]   filt_d;
   logic [WIDTH-1:0]   rise_en;
   logic [WIDTH-1:0]   fall_en;
   logic [WIDTH-1:0]   irq_mask;
   logic [WIDTH-1:0]   edge_capture;
   logic [WIDTH-1:0]   edge_set;
   logic [WIDTH-1:0]   cap_clr;
   logic [DB_BITS-1:0] db_thresh;
   logic [BUS_W-1:0]   rd_word;
   logic               wr;
   logic               unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce_bit #(.DB_BITS(DB_BITS)) u_bit (
         .clk       (clk),
         .reset     (reset),
         .in_bit    (in_port[i]),
         .db_thresh (db_thresh),
         .filt      (filt[i]),
         .filt_d    (filt_d[i])
      );
   end

   assign wr           = bus.chipselect & ~bus.write_n;
   assign edge_set     = (filt & ~filt_d & rise_en) | (~filt & filt_d & fall_en);
   assign cap_clr      = (wr && bus.address == ADDR_CAP) ? bus.writedata[WIDTH-1:0] : '0;
   assign bus.irq      = |(edge_capture & irq_mask);
   assign unused_wdata = ^bus.writedata;

   always_comb begin
      rd_word = '0;
      case (bus.address)
         ADDR_DATA: rd_word[WIDTH-1:0]   = filt;
         ADDR_RISE: rd_word[WIDTH-1:0]   = rise_en;
         ADDR_MASK: rd_word[WIDTH-1:0]   = irq_mask;
         ADDR_CAP:  rd_word[WIDTH-1:0]   = edge_capture;
         ADDR_FALL: rd_word[WIDTH-1:0]   = fall_en;
         ADDR_DB:   rd_word[DB_BITS-1:0] = db_thresh;
         default:   rd_word = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rise_en      <= RESET_RISE_EN;
         fall_en      <= '0;
         irq_mask     <= '0;
         edge_capture <= '0;
         db_thresh    <= '0;
         bus.readdata <= '0;
      end else begin
         bus.readdata <= rd_word;
         // new edges win over a same-cycle write-1-to-clear
         edge_capture <= (edge_capture & ~cap_clr) | edge_set;
         if (wr) begin
            case (bus.address)
               ADDR_RISE: rise_en   <= bus.writedata[WIDTH-1:0];
               ADDR_MASK: irq_mask  <= bus.writedata[WIDTH-1:0];
               ADDR_FALL: fall_en   <= bus.writedata[WIDTH-1:0];
               ADDR_DB:   db_thresh <= bus.writedata[DB_BITS-1:0];
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pio_edge_in.sv
// Directed self-checking bench for pio_edge_in (WIDTH=8, DB_BITS=16).
module tb_pio_edge_in;
   import pio_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_port;
   int         checks = 0;
   int         errors = 0;

   pio_edge_in_if bus ();

   pio_edge_in #(
      .WIDTH         (8),
      .DB_BITS       (16),
      .RESET_RISE_EN (8'hFF)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .in_port (in_port),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] addr, input logic [31:0] data);
      bus.address    = addr;
      bus.writedata  = data;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      tick();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] addr, input string tag, input logic [31:0] exp);
      bus.address = addr;
      tick();
      check(tag, bus.readdata, exp);
   endtask

   initial begin
      reset          = 1'b1;
      in_port        = 8'h00;
      bus.address    = '0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      tick();
      tick();
      check("rst_readdata", bus.readdata, 32'h0);
      check("rst_irq", 32'(bus.irq), 32'h0);
      reset = 1'b0;
      rd(ADDR_DATA, "rst_data", 32'h00);
      rd(ADDR_RISE, "rst_rise_en", 32'hFF);
      rd(ADDR_MASK, "rst_mask", 32'h00);
      rd(ADDR_CAP,  "rst_cap", 32'h00);
      rd(ADDR_FALL, "rst_fall_en", 32'h00);
      rd(ADDR_DB,   "rst_db", 32'h00);

      // bit0 rise with zero threshold: filt at e2, capture/irq at e3
      wr(ADDR_MASK, 32'h01);
      in_port     = 8'h01;
      bus.address = ADDR_DATA;
      tick(); tick(); tick();
      check("lat_data_e2", bus.readdata, 32'h00);
      check("lat_irq_e2", 32'(bus.irq), 32'h0);
      tick();
      check("lat_data_e3", bus.readdata, 32'h01);
      check("lat_irq_e3", 32'(bus.irq), 32'h1);
      rd(ADDR_CAP, "cap_b0", 32'h01);

      // write-1-to-clear, then clear racing a new rise
      wr(ADDR_CAP, 32'h01);
      check("clr_irq", 32'(bus.irq), 32'h0);
      rd(ADDR_CAP, "clr_cap", 32'h00);
      in_port = 8'h00;
      repeat (4) tick();
      rd(ADDR_CAP, "fall_not_en", 32'h00);
      in_port = 8'h02;
      repeat (4) tick();
      rd(ADDR_CAP, "cap_b1", 32'h02);
      check("irq_masked", 32'(bus.irq), 32'h0);
      in_port = 8'h03;
      tick(); tick(); tick();
      wr(ADDR_CAP, 32'h03);
      check("race_irq", 32'(bus.irq), 32'h1);
      rd(ADDR_CAP, "race_cap", 32'h01);
      wr(ADDR_CAP, 32'hFF);
      rd(ADDR_CAP, "clr_all", 32'h00);

      // fall-only on bit1
      wr(ADDR_RISE, 32'h00);
      wr(ADDR_FALL, 32'h02);
      in_port = 8'h01;
      repeat (4) tick();
      rd(ADDR_CAP, "fall_b1", 32'h02);
      wr(ADDR_CAP, 32'h02);
      in_port = 8'h03;
      repeat (5) tick();
      rd(ADDR_CAP, "rise_not_en", 32'h00);
      rd(ADDR_DATA, "data_03", 32'h03);

      // debounce threshold 5 on bit2: 4-cycle glitch rejected, 7-cycle pulse accepted
      wr(ADDR_FALL, 32'h00);
      wr(ADDR_RISE, 32'h04);
      wr(ADDR_DB, 32'h05);
      in_port     = 8'h07;
      bus.address = ADDR_DATA;
      repeat (4) tick();
      in_port = 8'h03;
      repeat (10) tick();
      check("glitch_data", bus.readdata, 32'h03);
      rd(ADDR_CAP, "glitch_cap", 32'h00);
      in_port     = 8'h07;
      bus.address = ADDR_DATA;
      repeat (7) tick();
      check("db_e6", bus.readdata, 32'h03);
      in_port = 8'h03;
      tick();
      check("db_e7", bus.readdata, 32'h03);
      tick();
      check("db_e8", bus.readdata, 32'h07);
      rd(ADDR_CAP, "db_cap", 32'h04);
      repeat (20) tick();
      rd(ADDR_DATA, "db_fall", 32'h03);

      // lowering the threshold below the running count
      wr(ADDR_DB, 32'd10);
      in_port = 8'h07;
      repeat (7) tick();
      wr(ADDR_DB, 32'd2);
      bus.address = ADDR_DATA;
      tick();
      check("thr_drop_e8", bus.readdata, 32'h03);
      tick();
      check("thr_drop_e9", bus.readdata, 32'h07);

      // reset in the middle of a debounce count
      wr(ADDR_MASK, 32'h04);
      wr(ADDR_DB, 32'd5);
      wr(ADDR_FALL, 32'h04);
      check("pre_rst_irq", 32'(bus.irq), 32'h1);
      in_port = 8'h03;
      repeat (5) tick();
      reset   = 1'b1;
      in_port = 8'h00;
      #1;
      check("async_rst_irq", 32'(bus.irq), 32'h0);
      check("async_rst_rdata", bus.readdata, 32'h0);
      tick();
      tick();
      reset = 1'b0;
      rd(ADDR_DATA, "mid_rst_data", 32'h00);
      rd(ADDR_RISE, "mid_rst_rise", 32'hFF);
      rd(ADDR_MASK, "mid_rst_mask", 32'h00);
      rd(ADDR_CAP,  "mid_rst_cap", 32'h00);
      rd(ADDR_FALL, "mid_rst_fall", 32'h00);
      rd(ADDR_DB,   "mid_rst_db", 32'h00);

      // input high through reset: captured only after normal latency
      reset   = 1'b1;
      in_port = 8'h01;
      tick();
      reset       = 1'b0;
      bus.address = ADDR_CAP;
      tick(); tick(); tick(); tick();
      check("rel_cap_e3", bus.readdata, 32'h00);
      tick();
      check("rel_cap_e4", bus.readdata, 32'h01);

      // unused addresses
      wr(3'd6, 32'hFFFF_FFFF);
      wr(3'd7, 32'hFFFF_FFFF);
      rd(3'd6, "rd_addr6", 32'h0);
      rd(3'd7, "rd_addr7", 32'h0);
      rd(ADDR_RISE, "a67_rise", 32'hFF);
      rd(ADDR_MASK, "a67_mask", 32'h00);
      rd(ADDR_CAP,  "a67_cap", 32'h01);
      rd(ADDR_FALL, "a67_fall", 32'h00);
      rd(ADDR_DB,   "a67_db", 32'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
